gbuff_skew_feeder: RTL and testbench

Reads a contiguous run of words from the global buffer and delivers them to the systolic array's left edge as a diagonally skewed operand wavefront. Lane r of each word is delayed r cycles. The array then sees operand k of row r in the correct cycle. The block sits directly downstream of the global buffer read port and directly upstream of the PE array. It owns the buffer index while busy.

---
 rtl/tpu_pkg.sv | 16 +
 rtl/skew_delay_line.sv | 47 ++++
 rtl/gbuff_skew_feeder.sv | 111 +++++++++++
 tb/tb_gbuff_skew_feeder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU front-end defaults (global buffer geometry) and the operand feeder state encoding.
package tpu_pkg;

  localparam int unsigned TPU_ROWS      = 5;
  localparam int unsigned TPU_DATA_SIZE = 8;
  localparam int unsigned TPU_WORD_SIZE = TPU_ROWS * TPU_DATA_SIZE;
  localparam int unsigned TPU_INDX_SIZE = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// One feeder lane: a capture register followed by DEPTH skew stages, carrying data and valid.
module skew_delay_line #(
  parameter int unsigned DEPTH = 0,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             vld,
  output logic [WIDTH-1:0] dly_data,
  output logic             dly_vld,
  output logic             pend_c
);

  localparam int unsigned STAGES = DEPTH + 1;

  logic [WIDTH-1:0]  data_q [STAGES];
  logic [STAGES-1:0] vld_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned j = 0; j < STAGES; j++) begin
        data_q[j] <= '0;
      end
      vld_q <= '0;
    end else begin
      data_q[0] <= data;
      vld_q[0]  <= vld;
      for (int unsigned j = 1; j < STAGES; j++) begin
        data_q[j] <= data_q[j-1];
        vld_q[j]  <= vld_q[j-1];
      end
    end
  end

  assign dly_data = data_q[STAGES-1];
  assign dly_vld  = vld_q[STAGES-1];

  // Valid still travelling toward the output; the last stage is excluded.
  always_comb begin
    pend_c = 1'b0;
    for (int unsigned j = 0; j + 1 < STAGES; j++) begin
      pend_c = pend_c | vld_q[j];
    end
  end

endmodule

// File: rtl/gbuff_skew_feeder.sv
// Streams a run of global buffer words into the PE array as a diagonally skewed wavefront.
// Build option FEEDER_ZERO_GATE_EN: zero each a_out lane whenever its a_vld bit is low.
module gbuff_skew_feeder
  import tpu_pkg::*;
#(
  parameter int unsigned ROWS      = TPU_ROWS,
  parameter int unsigned DATA_SIZE = TPU_DATA_SIZE,
  parameter int unsigned WORD_SIZE = ROWS * DATA_SIZE,
  parameter int unsigned INDX_SIZE = TPU_INDX_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [INDX_SIZE-1:0] base_addr,
  input  logic [INDX_SIZE-1:0] k_len,
  output logic                 busy,
  output logic                 done,
  output logic                 gb_req,
  output logic                 gb_wr_en,
  output logic [INDX_SIZE-1:0] gb_index,
  input  logic [WORD_SIZE-1:0] gb_data,
  output logic [WORD_SIZE-1:0] a_out,
  output logic [ROWS-1:0]      a_vld
);

  feeder_state_e state_q, state_d;

  logic [INDX_SIZE-1:0] base_q;
  logic [INDX_SIZE-1:0] len_q;
  logic [INDX_SIZE-1:0] rd_cnt_q;
  logic                 rd_vld_q;
  logic [ROWS-1:0]      lane_pend;
  logic [DATA_SIZE-1:0] lane_data [ROWS];
  logic                 drain_pend_c;

  // Anything still upstream of the lane outputs keeps a_vld alive next cycle.
  assign drain_pend_c = rd_vld_q | (|lane_pend);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (k_len == '0) ? DONE : READ;
      READ:    if (rd_cnt_q == len_q - INDX_SIZE'(1)) state_d = DRAIN;
      DRAIN:   if (!drain_pend_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    gb_req   = (state_q == READ);
    gb_wr_en = 1'b0;
    gb_index = gb_req ? base_q + rd_cnt_q : '0;
  end

  // Run parameters, read counter and the read-return valid flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      base_q   <= '0;
      len_q    <= '0;
      rd_cnt_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= (state_q == READ);
      if (state_q == IDLE && start) begin
        base_q   <= base_addr;
        len_q    <= k_len;
        rd_cnt_q <= '0;
      end else if (state_q == READ) begin
        rd_cnt_q <= rd_cnt_q + INDX_SIZE'(1);
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    skew_delay_line #(
      .DEPTH (r),
      .WIDTH (DATA_SIZE)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .data     (gb_data[r*DATA_SIZE +: DATA_SIZE]),
      .vld      (rd_vld_q),
      .dly_data (lane_data[r]),
      .dly_vld  (a_vld[r]),
      .pend_c   (lane_pend[r])
    );
  end

  always_comb begin
    a_out = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
`ifdef FEEDER_ZERO_GATE_EN
      a_out[r*DATA_SIZE +: DATA_SIZE] = a_vld[r] ? lane_data[r] : '0;
`else
      a_out[r*DATA_SIZE +: DATA_SIZE] = lane_data[r];
`endif
    end
  end

endmodule

// File: tb/tb_gbuff_skew_feeder.sv
// Bench for gbuff_skew_feeder: per-cycle comparison against a timing model of the skewed wavefront.
module tb_gbuff_skew_feeder;

  localparam int unsigned ROWS = 5;
  localparam int unsigned DS   = 8;
  localparam int unsigned WS   = ROWS * DS;
  localparam int unsigned IW   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [IW-1:0] base_addr;
  logic [IW-1:0] k_len;
  logic          busy, done, gb_req, gb_wr_en;
  logic [IW-1:0] gb_index;
  logic [WS-1:0] gb_data;
  logic [WS-1:0] a_out;
  logic [ROWS-1:0] a_vld;

  int checks   = 0;
  int failures = 0;
  int cur_t    = 0;

  logic [WS-1:0] mem [256];

  gbuff_skew_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .k_len     (k_len),
    .busy      (busy),
    .done      (done),
    .gb_req    (gb_req),
    .gb_wr_en  (gb_wr_en),
    .gb_index  (gb_index),
    .gb_data   (gb_data),
    .a_out     (a_out),
    .a_vld     (a_vld)
  );

  always #5 clk = ~clk;

  // Global buffer: synchronous read, data one cycle after the index.
  always @(posedge clk) gb_data <= mem[gb_index];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, cur_t, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_done"},  64'(done), 64'd0);
    chk({tag, "_req"},   64'(gb_req), 64'd0);
    chk({tag, "_index"}, 64'(gb_index), 64'd0);
    chk({tag, "_vld"},   64'(a_vld), 64'd0);
    chk({tag, "_aout"},  64'(a_out), 64'd0);
  endtask

  // Called in an idle cycle, which becomes cycle 0 of the run.
  task automatic run(input logic [IW-1:0] base, input int k, input int restart_t, input int rst_t);
    int done_t;
    int i;
    logic [ROWS-1:0] ev;
    logic [WS-1:0]   eo;
    logic [WS-1:0]   mask;
    logic [IW-1:0]   eidx;
    done_t    = (k == 0) ? 1 : k + int'(ROWS) + 2;
    start     = 1'b1;
    base_addr = base;
    k_len     = IW'(k);
    for (int t = 1; t <= done_t + 1; t++) begin
      tick();
      cur_t     = t;
      start     = 1'b0;
      base_addr = IW'($urandom);
      k_len     = IW'($urandom);
      if (rst_t >= 0 && t == rst_t + 1) begin
        chk_all_zero("abort");
        rst = 1'b1;
        return;
      end
      ev   = '0;
      eo   = '0;
      mask = '0;
      for (int r = 0; r < int'(ROWS); r++) begin
        i = t - 3 - r;
        if (i >= 0 && i < k) begin
          ev[r] = 1'b1;
          eo[r*DS +: DS] = mem[(int'(base) + i) & 255][r*DS +: DS];
          mask[r*DS +: DS] = '1;
        end
      end
`ifdef FEEDER_ZERO_GATE_EN
      mask = '1;
`endif
      eidx = (t >= 1 && t <= k) ? IW'(int'(base) + t - 1) : '0;
      chk("busy",  64'(busy), 64'(t <= done_t));
      chk("done",  64'(done), 64'(t == done_t));
      chk("req",   64'(gb_req), 64'(t >= 1 && t <= k));
      chk("wr_en", 64'(gb_wr_en), 64'd0);
      chk("index", 64'(gb_index), 64'(eidx));
      chk("vld",   64'(a_vld), 64'(ev));
      chk("aout",  64'(a_out & mask), 64'(eo));
      if (t == restart_t) begin
        start     = 1'b1;
        base_addr = 8'h55;
        k_len     = 8'd5;
      end
      if (t == rst_t) rst = 1'b0;
    end
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    k_len     = '0;
    for (int a = 0; a < 256; a++) mem[a] = WS'({$urandom, $urandom});
    for (int i = 0; i < 4; i++)
      for (int r = 0; r < int'(ROWS); r++)
        mem[16 + i][r*DS +: DS] = DS'(160 + i + r);

    tick();
    tick();
    chk_all_zero("reset");
    chk("reset_wr_en", 64'(gb_wr_en), 64'd0);
    rst = 1'b1;
    tick();

    run(8'h10, 4, -1, -1);
    run(8'hFE, 3, -1, -1);
    run(8'h00, 0, -1, -1);
    run(8'h20, 4, 5, -1);
    run(8'h30, 4, -1, 6);
    run(8'h40, 4, -1, -1);
    run(8'hFF, 1, -1, -1);
    for (int n = 0; n < 6; n++) begin
      run(IW'($urandom), int'($urandom_range(1, 12)), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
